dsp_mac_pipe: RTL and testbench

- Parametrised, pipelined multiply-accumulate engine; successor to the fixed 16x16 DSP multiplier, muladd and PE wrappers.
- Runtime-selectable op per beat:
  - MUL: a*b
  - MULADD: a*b+s
  - PE: a*b + m*q + s
  - ACC: running sum of a*b + m*q over a first..last burst
- Sits between Montgomery-multiplier control and the limb arrays. Adds valid/ready flow control and accumulation, which the fixed-latency wrappers lack.

---
 rtl/dsp_mac_pipe.sv | 139 +++++++++++++
 tb/tb_dsp_mac_pipe.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_pipe.sv
// Pipelined unsigned multiply-accumulate engine: MUL, MULADD, PE and burst ACC ops
// with valid/ready flow control and a single global advance enable.
module dsp_mac_pipe #(
    parameter int AW  = 16,
    parameter int BW  = 16,
    parameter int SW  = 48,
    parameter int LAT = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_op,
    input  logic          in_first,
    input  logic          in_last,
    input  logic [AW-1:0] in_a,
    input  logic [BW-1:0] in_b,
    input  logic [AW-1:0] in_m,
    input  logic [BW-1:0] in_q,
    input  logic [SW-1:0] in_s,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] out_s
);
    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULADD = 2'b01;
    localparam logic [1:0] OP_PE     = 2'b10;
    localparam logic [1:0] OP_ACC    = 2'b11;
    localparam int PW = AW + BW;

    if (LAT < 1 || LAT > 4) begin : g_bad_lat
        $error("dsp_mac_pipe: LAT must be in 1..4");
    end

    typedef struct packed {
        logic [1:0]    op;
        logic          first;
        logic          last;
        logic [SW-1:0] term;
    } beat_t;

    // Full-width product brought into the SW-bit modular domain.
    function automatic logic [SW-1:0] fit_prod(input logic [PW-1:0] p);
        return SW'(p);
    endfunction

    function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] x, input logic [SW-1:0] y);
        return x + y;
    endfunction

    logic          ce;
    logic          rdy_en;
    logic          vld_in;
    logic [PW-1:0] prod_ab;
    logic [PW-1:0] prod_mq;
    logic [SW-1:0] term_in;
    beat_t         beat_in;
    logic          vld_tail;
    beat_t         beat_tail;
    logic [SW-1:0] acc;
    logic [SW-1:0] acc_next;

    assign ce       = !out_valid || out_ready;
    assign in_ready = rdy_en && ce;
    assign vld_in   = in_valid && in_ready;

    assign prod_ab = PW'(in_a) * PW'(in_b);
    assign prod_mq = PW'(in_m) * PW'(in_q);

    always_comb begin
        term_in = fit_prod(prod_ab);
        case (in_op)
            OP_MUL:    term_in = fit_prod(prod_ab);
            OP_MULADD: term_in = wrap_add(fit_prod(prod_ab), in_s);
            OP_PE:     term_in = wrap_add(wrap_add(fit_prod(prod_ab), fit_prod(prod_mq)), in_s);
            OP_ACC:    term_in = wrap_add(fit_prod(prod_ab), fit_prod(prod_mq));
            default:   term_in = fit_prod(prod_ab);
        endcase
    end

    assign beat_in = {in_op, in_first, in_last, term_in};

    // ---- stages 0..LAT-2: delay line; only the valid bits see reset ----
    if (LAT == 1) begin : g_direct
        assign vld_tail  = vld_in;
        assign beat_tail = beat_in;
    end else begin : g_pipe
        logic  vld_p  [LAT-1];
        beat_t beat_p [LAT-1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < LAT-1; k++) vld_p[k] <= 1'b0;
            end else if (ce) begin
                vld_p[0] <= vld_in;
                for (int k = 1; k < LAT-1; k++) vld_p[k] <= vld_p[k-1];
            end
        end

        always_ff @(posedge clk) begin
            if (ce) begin
                beat_p[0] <= beat_in;
                for (int k = 1; k < LAT-1; k++) beat_p[k] <= beat_p[k-1];
            end
        end

        assign vld_tail  = vld_p[LAT-2];
        assign beat_tail = beat_p[LAT-2];
    end

    // ---- final stage: accumulator resolved here, in acceptance order ----
    assign acc_next = beat_tail.first ? beat_tail.term : wrap_add(acc, beat_tail.term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en    <= 1'b0;
            out_valid <= 1'b0;
            out_s     <= '0;
            acc       <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (ce) begin
                out_valid <= 1'b0;
                if (vld_tail) begin
                    if (beat_tail.op == OP_ACC) begin
                        acc <= acc_next;
                        if (beat_tail.last) begin
                            out_valid <= 1'b1;
                            out_s     <= acc_next;
                        end
                    end else begin
                        out_valid <= 1'b1;
                        out_s     <= beat_tail.term;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed bench for dsp_mac_pipe: reference model of the op rules plus a
// per-cycle scoreboard, with literal expectations on each directed case.
module tb_dsp_mac_pipe;
    localparam int AW  = 16;
    localparam int BW  = 16;
    localparam int SW  = 48;
    localparam int LAT = 3;
    localparam longint unsigned MASK = (64'd1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_op = '0;
    logic          in_first = 1'b0;
    logic          in_last = 1'b0;
    logic [AW-1:0] in_a = '0;
    logic [BW-1:0] in_b = '0;
    logic [AW-1:0] in_m = '0;
    logic [BW-1:0] in_q = '0;
    logic [SW-1:0] in_s = '0;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_s;

    dsp_mac_pipe #(.AW(AW), .BW(BW), .SW(SW), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_first(in_first), .in_last(in_last),
        .in_a(in_a), .in_b(in_b), .in_m(in_m), .in_q(in_q), .in_s(in_s),
        .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s)
    );

    always #5 clk = ~clk;

    int              n_cmp = 0;
    int              n_fail = 0;
    longint unsigned exp_q[$];
    longint unsigned macc = 0;
    int              cyc = 0;
    int              rel_edges = 0;
    int              n_out = 0;
    longint unsigned last_out = 0;
    int              acc_cyc = 0;
    int              out_cyc = 0;
    logic            prev_stall = 1'b0;
    longint unsigned prev_s = 0;
    logic            bp_mode = 1'b0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) rel_edges <= 0;
        else if (rel_edges < 4) rel_edges <= rel_edges + 1;
    end

    // Downstream readiness: always ready, or a 1,0,0,1 pattern under backpressure.
    initial begin
        logic pat [4];
        int   k;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        k = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                out_ready = pat[k % 4];
                k++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    task automatic model_accept();
        longint unsigned ab, mq, t;
        ab = longint'(in_a) * longint'(in_b);
        mq = longint'(in_m) * longint'(in_q);
        case (in_op)
            2'b00: exp_q.push_back(ab & MASK);
            2'b01: exp_q.push_back((ab + in_s) & MASK);
            2'b10: exp_q.push_back((ab + mq + in_s) & MASK);
            default: begin
                t = (ab + mq) & MASK;
                macc = in_first ? t : ((macc + t) & MASK);
                if (in_last) exp_q.push_back(macc);
            end
        endcase
        acc_cyc = cyc;
    endtask

    // Scoreboard: samples on the falling edge, between active edges.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_out_valid", out_valid, 0);
                check("rst_out_s", out_s, 0);
                check("rst_in_ready", in_ready, 0);
                exp_q.delete();
                macc = 0;
                prev_stall = 1'b0;
            end else begin
                check("in_ready_ce", in_ready, (rel_edges > 0) && (!out_valid || out_ready));
                if (prev_stall) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_hold", out_s, prev_s);
                end
                if (out_valid && out_ready) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_out: got 0x%0h expected no output", out_s);
                    end else begin
                        n_cmp--;
                        check("out_s", out_s, exp_q.pop_front());
                    end
                    n_out++;
                    last_out = out_s;
                    out_cyc = cyc;
                end
                prev_stall = out_valid && !out_ready;
                prev_s = out_s;
                if (in_valid && in_ready) model_accept();
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic f, input logic l,
                        input longint unsigned a, input longint unsigned b,
                        input longint unsigned m, input longint unsigned q,
                        input longint unsigned s);
        int k;
        in_op = op; in_first = f; in_last = l;
        in_a = a[AW-1:0]; in_b = b[BW-1:0]; in_m = m[AW-1:0]; in_q = q[BW-1:0];
        in_s = s[SW-1:0];
        in_valid = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!in_ready && k < 20);
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 20 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 100) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", in_ready, 1);
        check("idle_valid", out_valid, 0);
        check("idle_out_s", out_s, 0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_valid_late", out_valid, 0);

        // MUL latency and full-width product
        send(2'b00, 0, 0, 'hFFFF, 'hFFFF, 0, 0, 0);
        drain();
        check("mul_value", last_out, 64'hFFFE0001);
        check("mul_latency", longint'(out_cyc - acc_cyc), LAT);

        // PE, wrap, ignored operands
        send(2'b10, 0, 0, 2, 3, 5, 7, 1);
        drain();
        check("pe_value", last_out, 42);
        send(2'b10, 0, 0, 0, 0, 0, 0, 64'hFFFFFFFFFFFF);
        drain();
        check("pe_s_only", last_out, 64'hFFFFFFFFFFFF);
        send(2'b01, 0, 0, 1, 1, 0, 0, 64'hFFFFFFFFFFFF);
        drain();
        check("muladd_wrap", last_out, 0);
        send(2'b00, 0, 0, 7, 6, 9, 9, 123);
        drain();
        check("mul_ignores_mqs", last_out, 42);

        // ACC burst with an interleaved MUL
        n0 = n_out;
        send(2'b11, 1, 0, 1, 2, 1, 0, 55);
        send(2'b11, 0, 0, 2, 2, 1, 1, 0);
        send(2'b00, 0, 0, 3, 5, 0, 0, 0);
        send(2'b11, 0, 0, 3, 2, 1, 2, 0);
        send(2'b11, 0, 1, 4, 2, 1, 3, 0);
        drain();
        check("acc_burst_sum", last_out, 26);
        check("acc_burst_count", n_out - n0, 2);
        send(2'b11, 1, 1, 3, 3, 0, 0, 0);
        drain();
        check("acc_single", last_out, 9);
        send(2'b11, 0, 1, 1, 1, 0, 0, 0);
        drain();
        check("acc_stale_continue", last_out, 10);

        // Backpressure stream
        n0 = n_out;
        bp_mode = 1'b1;
        for (int i = 0; i < 8; i++) send(2'b00, 0, 0, i, 10, 0, 0, 0);
        drain();
        bp_mode = 1'b0;
        check("bp_count", n_out - n0, 8);
        check("bp_last", last_out, 70);

        // Reset with beats in flight
        send(2'b11, 1, 0, 1, 1, 0, 0, 0);
        send(2'b11, 0, 0, 2, 2, 0, 0, 0);
        send(2'b00, 0, 0, 5, 5, 0, 0, 0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        n0 = n_out;
        @(posedge clk);
        #1;
        send(2'b11, 1, 1, 4, 4, 0, 0, 0);
        drain();
        check("post_reset_value", last_out, 16);
        repeat (10) @(posedge clk);
        #1;
        check("post_reset_count", n_out - n0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
